clint: RTL and testbench

Core-local interrupt source for the pipelined RV32I core with exceptions and interrupts. It sits beside the data memory on the core's load/store path and holds the machine software-interrupt bit, a 64-bit free-running `mtime` with programmable prescaler, and a 64-bit `mtimecmp`. It drives level-sensitive `timer_irq` and `soft_irq` into the core's interrupt/CSR logic. All state is word-addressed through a simple select/write/read port with one-cycle read latency.

---
 rtl/clint.sv | 111 +++++++++++
 tb/tb_clint.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// rtl/clint.sv - Core-local interruptor: msip, prescaled 64-bit mtime, mtimecmp, level irqs.
module clint #(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [4:0]  adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        timer_irq,
    output logic        soft_irq
);

    logic        msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] prescale;
    logic [15:0] pcnt;

    logic [2:0]  reg_idx;
    logic        wr_en;
    logic        rd_en;
    logic        unused_adr;

    logic        wr_msip;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_prescale;

    logic        pcnt_hit;
    logic        tick;
    logic        lo_carry;
    logic [15:0] pcnt_next;
    logic [31:0] mtime_lo_next;
    logic [31:0] mtime_hi_next;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_next;
    logic        msip_next;
    logic [31:0] rd_value;

    assign reg_idx    = adr[4:2];
    assign unused_adr = ^adr[1:0];
    assign wr_en      = sel & we;
    assign rd_en      = sel & ~we;

    assign wr_msip     = wr_en && (reg_idx == 3'd0);
    assign wr_cmp_lo   = wr_en && (reg_idx == 3'd1);
    assign wr_cmp_hi   = wr_en && (reg_idx == 3'd2);
    assign wr_mtime_lo = wr_en && (reg_idx == 3'd3);
    assign wr_mtime_hi = wr_en && (reg_idx == 3'd4);
    assign wr_prescale = wr_en && (reg_idx == 3'd5);

    // A prescale write restarts the divider and suppresses the tick of that edge.
    assign pcnt_hit  = (pcnt == prescale);
    assign tick      = pcnt_hit & ~wr_prescale;
    assign pcnt_next = (wr_prescale || pcnt_hit) ? 16'd0 : pcnt + 16'd1;

    // The carry into hi always comes from the pre-edge lo, even when lo is being written.
    assign lo_carry      = tick & (&mtime[31:0]);
    assign mtime_lo_next = wr_mtime_lo ? wdata : mtime[31:0] + {31'd0, tick};
    assign mtime_hi_next = wr_mtime_hi ? wdata : mtime[63:32] + {31'd0, lo_carry};
    assign mtime_next    = {mtime_hi_next, mtime_lo_next};

    assign mtimecmp_next = {wr_cmp_hi ? wdata : mtimecmp[63:32],
                            wr_cmp_lo ? wdata : mtimecmp[31:0]};
    assign msip_next     = wr_msip ? wdata[0] : msip;

    always_comb begin
        rd_value = 32'd0;
        case (reg_idx)
            3'd0:    rd_value = {31'd0, msip};
            3'd1:    rd_value = mtimecmp[31:0];
            3'd2:    rd_value = mtimecmp[63:32];
            3'd3:    rd_value = mtime[31:0];
            3'd4:    rd_value = mtime[63:32];
            3'd5:    rd_value = {16'd0, prescale};
            default: rd_value = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msip      <= 1'b0;
            mtime     <= 64'd0;
            mtimecmp  <= MTIMECMP_RST;
            prescale  <= PRESCALE_RST;
            pcnt      <= 16'd0;
            rdata     <= 32'd0;
            rvalid    <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            msip      <= msip_next;
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            prescale  <= wr_prescale ? wdata[15:0] : prescale;
            pcnt      <= pcnt_next;
            rdata     <= rd_en ? rd_value : rdata;
            rvalid    <= rd_en;
            timer_irq <= (mtime_next >= mtimecmp_next);
        end
    end

    assign soft_irq = msip;

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - Directed vector table plus multi-cycle sequences for clint.
module tb_clint;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [4:0]  adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        timer_irq;
    logic        soft_irq;

    int tests = 0;
    int failed = 0;

    clint dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .we        (we),
        .adr       (adr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        we;
        logic [4:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_rvalid;
        logic        exp_irq;
        logic        exp_soft;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
        sel   = s;
        we    = w;
        adr   = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string name);
        step(1'b1, 1'b0, a, 32'd0);
        chk(name, {32'd0, rdata}, {32'd0, exp});
        chk({name, " rvalid"}, {63'd0, rvalid}, 64'd1);
    endtask

    initial begin
        // sel, we, adr, wdata, exp_rdata, exp_rvalid, exp_irq, exp_soft
        vecs.push_back('{1'b1, 1'b0, 5'h0C, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h10, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h00, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h04, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h08, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h14, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h18, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h1C, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h14, 32'h0000FFFF, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h14, 32'h0,        32'h0000FFFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h0C, 32'h5,        32'h0000FFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h10, 32'h12345678, 32'h0000FFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h0C, 32'h0,        32'h5,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h10, 32'h0,        32'h12345678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h00, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 5'h00, 32'h0,        32'h1,        1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 5'h00, 32'h0,        32'h1,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h00, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h18, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h18, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 5'h00, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h04, 32'h3,        32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h08, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h04, 32'h0,        32'h3,        1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 5'h04, 32'd100,      32'h3,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h08, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 5'h00, 32'h1,        32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 5'h07, 32'h0,        32'h64,       1'b1, 1'b0, 1'b0});

        rst_n = 1'b0;
        sel   = 1'b0;
        we    = 1'b0;
        adr   = 5'd0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdata", {32'd0, rdata}, 64'd0);
        chk("reset rvalid", {63'd0, rvalid}, 64'd0);
        chk("reset timer_irq", {63'd0, timer_irq}, 64'd0);
        chk("reset soft_irq", {63'd0, soft_irq}, 64'd0);
        rst_n = 1'b1;

        // mtime runs from 0 at prescale 0; mtime offsets are read first while still 0.
        foreach (vecs[i]) begin
            step(vecs[i].sel, vecs[i].we, vecs[i].adr, vecs[i].wdata);
            chk($sformatf("vec%0d rdata", i), {32'd0, rdata}, {32'd0, vecs[i].exp_rdata});
            chk($sformatf("vec%0d rvalid", i), {63'd0, rvalid}, {63'd0, vecs[i].exp_rvalid});
            chk($sformatf("vec%0d timer_irq", i), {63'd0, timer_irq}, {63'd0, vecs[i].exp_irq});
            chk($sformatf("vec%0d soft_irq", i), {63'd0, soft_irq}, {63'd0, vecs[i].exp_soft});
        end

        // Prescale 3 cadence: increments land every 4th edge after the write.
        step(1'b1, 1'b1, 5'h10, 32'h0);
        step(1'b1, 1'b1, 5'h0C, 32'h0);
        step(1'b1, 1'b1, 5'h14, 32'h3);
        for (int k = 1; k <= 41; k++) begin
            step(1'b1, 1'b0, 5'h0C, 32'h0);
            chk($sformatf("cadence k%0d", k), {32'd0, rdata}, 64'((k - 1) / 4));
        end

        // Timer irq rises when mtime reaches 20, falls when mtimecmp is raised.
        step(1'b1, 1'b1, 5'h08, 32'h0);
        step(1'b1, 1'b1, 5'h04, 32'd20);
        step(1'b1, 1'b1, 5'h10, 32'h0);
        step(1'b1, 1'b1, 5'h14, 32'h0);
        step(1'b1, 1'b1, 5'h0C, 32'h0);
        chk("irq after mtime clear", {63'd0, timer_irq}, 64'd0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 5'h00, 32'h0);
            chk($sformatf("irq_rise k%0d", k), {63'd0, timer_irq}, (k >= 20) ? 64'd1 : 64'd0);
        end
        step(1'b1, 1'b1, 5'h04, 32'd100);
        chk("irq fall on cmp write", {63'd0, timer_irq}, 64'd0);

        // Carry from lo into hi, and full 64-bit wrap.
        step(1'b1, 1'b1, 5'h10, 32'h0);
        step(1'b1, 1'b1, 5'h0C, 32'hFFFFFFFE);
        step(1'b1, 1'b1, 5'h14, 32'h0);
        step(1'b0, 1'b0, 5'h00, 32'h0);
        step(1'b0, 1'b0, 5'h00, 32'h0);
        rd_check(5'h0C, 32'h0, "carry lo");
        rd_check(5'h10, 32'h1, "carry hi");
        step(1'b1, 1'b1, 5'h10, 32'hFFFFFFFF);
        step(1'b1, 1'b1, 5'h0C, 32'hFFFFFFFF);
        chk("irq at all-ones", {63'd0, timer_irq}, 64'd1);
        step(1'b0, 1'b0, 5'h00, 32'h0);
        chk("irq after wrap", {63'd0, timer_irq}, 64'd0);
        rd_check(5'h0C, 32'h0, "wrap lo");
        rd_check(5'h10, 32'h0, "wrap hi");

        // Writing hi while lo overflows drops the carry.
        step(1'b1, 1'b1, 5'h0C, 32'hFFFFFFFF);
        step(1'b1, 1'b1, 5'h10, 32'h55);
        rd_check(5'h10, 32'h55, "hi write drops carry");
        rd_check(5'h0C, 32'h1, "lo wrapped under hi write");

        // Reset wins over a simultaneous write.
        step(1'b1, 1'b1, 5'h00, 32'h1);
        chk("soft before reset", {63'd0, soft_irq}, 64'd1);
        chk("irq before reset", {63'd0, timer_irq}, 64'd1);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 5'h04, 32'h0);
        chk("rst rdata", {32'd0, rdata}, 64'd0);
        chk("rst rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst timer_irq", {63'd0, timer_irq}, 64'd0);
        chk("rst soft_irq", {63'd0, soft_irq}, 64'd0);
        rst_n = 1'b1;
        rd_check(5'h04, 32'hFFFFFFFF, "rst cmp_lo write discarded");
        rd_check(5'h14, 32'h0, "rst prescale");
        rd_check(5'h00, 32'h0, "rst msip");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
